// File: rtl/read_bram_scalar2vector_if.sv
// Control, BRAM read port and line-push port of the scalar-to-vector BRAM reader.
// The master modport is the reader itself; the slave modport is its environment.
interface read_bram_scalar2vector_if;
  logic         op_start;
  logic [31:0]  configreg;
  logic         busy;
  logic         op_done;
  logic         bram_re;
  logic [15:0]  bram_raddr;
  logic [31:0]  bram_rdata;
  logic         out_we;
  logic [511:0] out_wdata;
  logic         out_almostfull;

  modport master (
    input  op_start,
    input  configreg,
    input  bram_rdata,
    input  out_almostfull,
    output busy,
    output op_done,
    output bram_re,
    output bram_raddr,
    output out_we,
    output out_wdata
  );

  modport slave (
    output op_start,
    output configreg,
    output bram_rdata,
    output out_almostfull,
    input  busy,
    input  op_done,
    input  bram_re,
    input  bram_raddr,
    input  out_we,
    input  out_wdata
  );
endinterface

// File: rtl/read_bram_scalar2vector.sv
// Reads 32-bit words from a local BRAM and packs 16 of them into each 512-bit line,
// pushing lines to a consumer that may stall the push with almostfull.
module read_bram_scalar2vector #(
  parameter int READ_LATENCY = 2
) (
  input logic                        clk,
  input logic                        reset,
  read_bram_scalar2vector_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    DRAIN = 3'd2,
    EMIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t       state_r;
  logic [15:0]  offset_r;
  logic [15:0]  length_r;
  logic [15:0]  line_r;
  logic [3:0]   pos_r;
  logic [4:0]   cap_cnt_r;
  logic         busy_r;
  logic         op_done_r;
  logic         bram_re_r;
  logic [15:0]  bram_raddr_r;
  logic [3:0]   bram_tag_r;
  logic         out_we_r;
  logic [511:0] out_wdata_r;
  logic [511:0] line_buf_r;
  logic         rv_vld_r [READ_LATENCY];
  logic [3:0]   rv_tag_r [READ_LATENCY];

  logic         cap_s;
  logic [3:0]   cap_tag_s;
  logic         last_line_s;

  // Word p of line i sits at offset + 16*i + p; the sum wraps modulo 2^16.
  function automatic logic [15:0] word_addr(input logic [15:0] base,
                                            input logic [15:0] line,
                                            input logic [3:0]  pos);
    word_addr = base + (line << 3'd4) + {12'd0, pos};
  endfunction

  assign cap_s       = rv_vld_r[READ_LATENCY-1];
  assign cap_tag_s   = rv_tag_r[READ_LATENCY-1];
  assign last_line_s = (line_r == (length_r - 16'd1));

  assign bus.busy       = busy_r;
  assign bus.op_done    = op_done_r;
  assign bus.bram_re    = bram_re_r;
  assign bus.bram_raddr = bram_raddr_r;
  assign bus.out_we     = out_we_r;
  assign bus.out_wdata  = out_wdata_r;

  // Operation sequencer: issues reads, counts captured words and pushes finished lines.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      offset_r     <= 16'd0;
      length_r     <= 16'd0;
      line_r       <= 16'd0;
      pos_r        <= 4'd0;
      cap_cnt_r    <= 5'd0;
      busy_r       <= 1'b0;
      op_done_r    <= 1'b0;
      bram_re_r    <= 1'b0;
      bram_raddr_r <= 16'd0;
      bram_tag_r   <= 4'd0;
      out_we_r     <= 1'b0;
      out_wdata_r  <= 512'd0;
    end else begin
      bram_re_r <= 1'b0;
      out_we_r  <= 1'b0;
      op_done_r <= 1'b0;
      if (cap_s) begin
        cap_cnt_r <= cap_cnt_r + 5'd1;
      end
      case (state_r)
        IDLE: begin
          if (bus.op_start) begin
            offset_r  <= bus.configreg[15:0];
            length_r  <= bus.configreg[31:16];
            line_r    <= 16'd0;
            pos_r     <= 4'd0;
            cap_cnt_r <= 5'd0;
            busy_r    <= 1'b1;
            if (bus.configreg[31:16] == 16'd0) begin
              op_done_r <= 1'b1;
              state_r   <= DONE;
            end else begin
              state_r   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          bram_re_r    <= 1'b1;
          bram_raddr_r <= word_addr(offset_r, line_r, pos_r);
          bram_tag_r   <= pos_r;
          pos_r        <= pos_r + 4'd1;
          if (pos_r == 4'd15) begin
            state_r <= DRAIN;
          end
        end
        DRAIN: begin
          if (cap_cnt_r == 5'd16) begin
            state_r <= EMIT;
          end
        end
        EMIT: begin
          // No reads are in flight here, so clearing the capture count cannot lose a word.
          if (!bus.out_almostfull) begin
            out_we_r    <= 1'b1;
            out_wdata_r <= line_buf_r;
            line_r      <= line_r + 16'd1;
            pos_r       <= 4'd0;
            cap_cnt_r   <= 5'd0;
            if (last_line_s) begin
              op_done_r <= 1'b1;
              state_r   <= DONE;
            end else begin
              state_r   <= ISSUE;
            end
          end
        end
        DONE: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Read-valid pipe follows each read to its data beat and steers the word into its slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        rv_vld_r[i] <= 1'b0;
        rv_tag_r[i] <= 4'd0;
      end
      line_buf_r <= 512'd0;
    end else begin
      rv_vld_r[0] <= bram_re_r;
      rv_tag_r[0] <= bram_tag_r;
      for (int i = 1; i < READ_LATENCY; i++) begin
        rv_vld_r[i] <= rv_vld_r[i-1];
        rv_tag_r[i] <= rv_tag_r[i-1];
      end
      if (cap_s) begin
        line_buf_r[{cap_tag_s, 5'd0} +: 32] <= bus.bram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_read_bram_scalar2vector.sv
// Self-checking bench: a latency-accurate BRAM model plus address/line scoreboards
// filled when each operation is started and drained as the reader produces output.
`timescale 1ns/1ps
module tb_read_bram_scalar2vector;
  localparam int RL = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  read_bram_scalar2vector_if bus_if();

  read_bram_scalar2vector #(.READ_LATENCY(RL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0]  seed = 32'h0;
  logic [31:0]  rd_pipe [RL];
  logic [15:0]  exp_addr_q [$];
  logic [511:0] exp_line_q [$];
  logic [511:0] last_line;

  function automatic logic [31:0] bram_fn(input logic [15:0] a);
    return seed ^ {16'h0000, a};
  endfunction

  // BRAM samples re/addr at a posedge; data is presented RL edges later.
  always @(posedge clk) begin
    rd_pipe[0] <= bus_if.bram_re ? bram_fn(bus_if.bram_raddr) : 32'hDEAD_BEEF;
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus_if.bram_rdata = rd_pipe[RL-1];

  task automatic run_op(input string name, input logic [15:0] offset, input logic [15:0] length,
                        input int af_until, input int poke_at);
    int budget, pushes, dones, done_c, first_push_c, post;
    bit after_done;
    logic [15:0]  a, exp_a;
    logic [511:0] line, exp_l;
    exp_addr_q.delete();
    exp_line_q.delete();
    for (int k = 0; k < int'(length); k++) begin
      for (int p = 0; p < 16; p++) begin
        a = offset + 16'(k * 16 + p);
        exp_addr_q.push_back(a);
        line[p*32 +: 32] = bram_fn(a);
      end
      exp_line_q.push_back(line);
    end
    budget = 40 + 40 * int'(length) + af_until;
    pushes = 0; dones = 0; done_c = -1; first_push_c = -1; post = 0; after_done = 1'b0;
    bus_if.configreg      = {length, offset};
    bus_if.op_start       = 1'b1;
    bus_if.out_almostfull = (af_until > 0);
    for (int c = 0; c < budget && post < 3; c++) begin
      @(negedge clk);
      if (bus_if.bram_re) begin
        checks++;
        if (exp_addr_q.size() == 0) begin
          errors++;
          $display("FAIL %s read_addr: got read at 0x%04h, expected no read", name, bus_if.bram_raddr);
        end else begin
          exp_a = exp_addr_q.pop_front();
          if (bus_if.bram_raddr !== exp_a) begin
            errors++;
            $display("FAIL %s read_addr: got 0x%04h, expected 0x%04h", name, bus_if.bram_raddr, exp_a);
          end
        end
      end
      if (bus_if.out_we) begin
        checks++;
        pushes++;
        if (first_push_c < 0) first_push_c = c;
        if (exp_line_q.size() == 0) begin
          errors++;
          $display("FAIL %s line_data: got unexpected push at cycle %0d, expected none", name, c);
        end else begin
          exp_l = exp_line_q.pop_front();
          if (bus_if.out_wdata !== exp_l) begin
            errors++;
            $display("FAIL %s line_data: got %h, expected %h", name, bus_if.out_wdata, exp_l);
          end
          last_line = exp_l;
        end
      end else begin
        checks++;
        if (bus_if.out_wdata !== last_line) begin
          errors++;
          $display("FAIL %s wdata_hold: got %h, expected %h", name, bus_if.out_wdata, last_line);
        end
      end
      if (bus_if.op_done) begin
        dones++;
        done_c = c;
      end
      checks++;
      if (bus_if.busy !== !after_done) begin
        errors++;
        $display("FAIL %s busy: got %b, expected %b at cycle %0d", name, bus_if.busy, !after_done, c);
      end
      if (after_done) post++;
      if (bus_if.op_done) after_done = 1'b1;
      bus_if.op_start = (c == poke_at);
      if (c == poke_at) bus_if.configreg = 32'h0007_0F00;
      bus_if.out_almostfull = (c < af_until);
    end
    bus_if.op_start       = 1'b0;
    bus_if.out_almostfull = 1'b0;
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL %s op_done_count: got %0d, expected 1", name, dones);
    end
    checks++;
    if (exp_addr_q.size() != 0) begin
      errors++;
      $display("FAIL %s read_count: got %0d reads missing, expected 0", name, exp_addr_q.size());
    end
    checks++;
    if (pushes != int'(length)) begin
      errors++;
      $display("FAIL %s push_count: got %0d, expected %0d", name, pushes, length);
    end
    checks++;
    if (length == 16'd0) begin
      if (done_c != 0) begin
        errors++;
        $display("FAIL %s done_latency: got cycle %0d, expected 0", name, done_c);
      end
    end else if (first_push_c < 17 + RL) begin
      errors++;
      $display("FAIL %s first_push_latency: got %0d, expected >= %0d", name, first_push_c, 17 + RL);
    end
    if (af_until > 0) begin
      checks++;
      if (first_push_c != af_until + 1) begin
        errors++;
        $display("FAIL %s af_release: got push at %0d, expected %0d", name, first_push_c, af_until + 1);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_if.op_start = 1'b0;
    bus_if.configreg = 32'h0;
    bus_if.out_almostfull = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus_if.busy, bus_if.op_done, bus_if.bram_re, bus_if.out_we} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, expected 0000",
               {bus_if.busy, bus_if.op_done, bus_if.bram_re, bus_if.out_we});
    end
    checks++;
    if (bus_if.bram_raddr !== 16'h0000) begin
      errors++;
      $display("FAIL reset_raddr: got 0x%04h, expected 0x0000", bus_if.bram_raddr);
    end
    checks++;
    if (bus_if.out_wdata !== 512'd0) begin
      errors++;
      $display("FAIL reset_wdata: got %h, expected 0", bus_if.out_wdata);
    end
    reset = 1'b0;
    last_line = 512'd0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus_if.busy, bus_if.op_done, bus_if.bram_re, bus_if.out_we} !== 4'b0000) begin
      errors++;
      $display("FAIL idle_quiet: got %b, expected 0000",
               {bus_if.busy, bus_if.op_done, bus_if.bram_re, bus_if.out_we});
    end
  endtask

  task automatic test_reset_midop();
    int pushes, reads2;
    bit hit;
    seed = 32'h5A5A_0000;
    bus_if.configreg = {16'd3, 16'h0100};
    bus_if.op_start  = 1'b1;
    pushes = 0; reads2 = 0; hit = 1'b0;
    for (int c = 0; c < 300 && !hit; c++) begin
      @(negedge clk);
      bus_if.op_start = 1'b0;
      if (bus_if.out_we) pushes++;
      else if (pushes == 2 && bus_if.bram_re) begin
        reads2++;
        if (reads2 == 3) hit = 1'b1;
      end
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL midop_reach: got %0d pushes %0d reads, expected 2 pushes 3 reads", pushes, reads2);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus_if.busy, bus_if.op_done, bus_if.bram_re, bus_if.out_we} !== 4'b0000) begin
      errors++;
      $display("FAIL midop_reset_ctrl: got %b, expected 0000",
               {bus_if.busy, bus_if.op_done, bus_if.bram_re, bus_if.out_we});
    end
    checks++;
    if (bus_if.bram_raddr !== 16'h0000 || bus_if.out_wdata !== 512'd0) begin
      errors++;
      $display("FAIL midop_reset_data: got raddr 0x%04h wdata nonzero=%b, expected 0", bus_if.bram_raddr,
               |bus_if.out_wdata);
    end
    reset = 1'b0;
    last_line = 512'd0;
    seed = 32'h0BAD_0000;
    run_op("after_reset", 16'h0040, 16'd2, 0, -1);
  endtask

  initial begin
    test_reset();
    seed = 32'h0;
    run_op("single_line", 16'h0000, 16'd1, 0, -1);
    run_op("multi_line", 16'h0020, 16'd3, 0, -1);
    run_op("zero_length", 16'h0010, 16'd0, 0, -1);
    seed = 32'hA5A5_0000;
    run_op("almostfull", 16'h0100, 16'd2, 31, -1);
    seed = 32'h1234_0000;
    run_op("addr_wrap", 16'hFFF8, 16'd1, 0, -1);
    seed = 32'h00C3_0000;
    run_op("ignore_start", 16'h0300, 16'd2, 0, 5);
    run_op("back_to_back", 16'h0305, 16'd1, 0, -1);
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
